// File: rtl/reflet_mem_responder.sv
// reflet_mem_responder
// Memory-side responder for the Reflet CPU RAM bus. Wraps a word-organised
// synchronous RAM and stretches every access by wait_states extra cycles so
// slow memory can be modelled. An access is started whenever the CPU presents
// a new address or raises write_en; mem_ready drops until the access finishes.
//
// Optional build macro: REFLET_MEM_RESPONDER_RANGE_CHECK_EN
//   defined   -> addresses beyond the RAM read as 0 and writes to them are dropped
//   undefined -> upper address bits are ignored and the word index wraps
module reflet_mem_responder #(
    parameter int wordsize    = 16,
    parameter int depth_log2  = 10,
    parameter int wait_states = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [wordsize-1:0] addr,
    input  logic [wordsize-1:0] data_in,
    input  logic                write_en,
    output logic [wordsize-1:0] data_out,
    output logic                mem_ready
);

    // Byte-offset bits dropped to form the word index (0 for 8-bit words).
    localparam int SHIFT = $clog2(wordsize / 8);
    localparam int DEPTH = 1 << depth_log2;
    localparam logic [3:0] WAIT_LOAD = 4'(wait_states);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS
    } state_t;

    state_t                state_reg, state_next;
    logic [3:0]            count_reg, count_next;
    logic [wordsize-1:0]   lat_addr_reg, lat_addr_next;
    logic [wordsize-1:0]   lat_data_reg, lat_data_next;
    logic                  lat_we_reg, lat_we_next;
    // Set once the first access after reset completes; holds mem_ready low
    // in the post-reset IDLE state until then.
    logic                  primed_reg, primed_next;
    logic [wordsize-1:0]   data_out_reg;

    logic                  trigger;
    logic [depth_log2-1:0] index;
    logic                  in_range;

    logic [wordsize-1:0]   ram [DEPTH];

    // A new address, or a rising write request on the same address, starts an access.
    assign trigger = (addr != lat_addr_reg) || (write_en && !lat_we_reg);

    // Word index of the latched address; truncation gives the wrap-around.
    assign index = depth_log2'(lat_addr_reg >> SHIFT);

`ifdef REFLET_MEM_RESPONDER_RANGE_CHECK_EN
    // Any address bit above the RAM's byte span marks the access out of range.
    assign in_range = ((lat_addr_reg >> (depth_log2 + SHIFT)) == '0);
`else
    assign in_range = 1'b1;
`endif

    assign data_out  = data_out_reg;
    assign mem_ready = (state_reg == S_IDLE) && primed_reg;

    // Next-state logic: latch new requests, count wait states, complete access.
    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        lat_addr_next = lat_addr_reg;
        lat_data_next = lat_data_reg;
        lat_we_next   = lat_we_reg;
        primed_next   = primed_reg;

        case (state_reg)
            S_IDLE, S_WAIT: begin
                if (trigger) begin
                    // A trigger in WAIT simply replaces the pending access.
                    lat_addr_next = addr;
                    lat_data_next = data_in;
                    lat_we_next   = write_en;
                    if (WAIT_LOAD != 4'd0) begin
                        state_next = S_WAIT;
                        count_next = WAIT_LOAD;
                    end else begin
                        state_next = S_ACCESS;
                        count_next = 4'd0;
                    end
                end else if (state_reg == S_WAIT) begin
                    count_next = count_reg - 4'd1;
                    if (count_reg <= 4'd1) begin
                        state_next = S_ACCESS;
                        count_next = 4'd0;
                    end
                end else if (!write_en) begin
                    // Released write request re-arms the write trigger without an access.
                    lat_we_next = 1'b0;
                end
            end
            S_ACCESS: begin
                state_next  = S_IDLE;
                primed_next = 1'b1;
            end
            default: begin
                state_next = S_IDLE;
                count_next = 4'd0;
            end
        endcase
    end

    // Control state register; lat_addr resets to all-ones to force a first read.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            count_reg    <= 4'd0;
            lat_addr_reg <= '1;
            lat_data_reg <= '0;
            lat_we_reg   <= 1'b0;
            primed_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            lat_addr_reg <= lat_addr_next;
            lat_data_reg <= lat_data_next;
            lat_we_reg   <= lat_we_next;
            primed_reg   <= primed_next;
        end
    end

    // RAM write port; contents survive reset, but a reset edge aborts the write.
    always_ff @(posedge clk) begin
        if (!reset && (state_reg == S_ACCESS) && lat_we_reg && in_range) begin
            ram[index] <= lat_data_reg;
        end
    end

    // Registered read / write-through data; holds between accesses.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_reg <= '0;
        end else if (state_reg == S_ACCESS) begin
            if (!in_range) begin
                data_out_reg <= '0;
            end else if (lat_we_reg) begin
                data_out_reg <= lat_data_reg;
            end else begin
                data_out_reg <= ram[index];
            end
        end
    end

endmodule
